// File: rtl/sw_hex_display.sv
// SW_HEX demo top: mirrors the slide switches on LEDR and shows them on the
// 7-segment displays as 3 hex digits or 4 decimal digits. KEY[1] toggles the mode.
module sw_hex_display (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_D     = 7'h21;

  function automatic logic [6:0] seg_hex(input logic [3:0] v);
    case (v)
      4'h0:    seg_hex = 7'h40;
      4'h1:    seg_hex = 7'h79;
      4'h2:    seg_hex = 7'h24;
      4'h3:    seg_hex = 7'h30;
      4'h4:    seg_hex = 7'h19;
      4'h5:    seg_hex = 7'h12;
      4'h6:    seg_hex = 7'h02;
      4'h7:    seg_hex = 7'h78;
      4'h8:    seg_hex = 7'h00;
      4'h9:    seg_hex = 7'h10;
      4'hA:    seg_hex = 7'h08;
      4'hB:    seg_hex = 7'h03;
      4'hC:    seg_hex = 7'h46;
      4'hD:    seg_hex = 7'h21;
      4'hE:    seg_hex = 7'h06;
      default: seg_hex = 7'h0E;
    endcase
  endfunction

  logic       rst;
  logic [9:0] sw_meta;
  logic [9:0] sw_q;
  logic       key_meta;
  logic       key_sync;
  logic       key_prev;
  logic [1:0] settle;
  logic       armed;
  logic       key_rise;
  mode_t      mode_q;
  mode_t      mode_d;
  logic [15:0] bcd;
  logic       unused_keys;

  assign rst         = KEY[0];
  assign unused_keys = ^KEY[3:2];

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_q     <= '0;
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      key_prev <= 1'b0;
      settle   <= '0;
      armed    <= 1'b0;
    end else begin
      sw_meta  <= SW;
      sw_q     <= sw_meta;
      key_meta <= KEY[1];
      key_sync <= key_meta;
      key_prev <= key_sync;
      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end
      // The synchronizer holds reset zeros for two edges; only once it has
      // refilled and shows the key released may an edge count, so a key held
      // across reset release never toggles.
      if (settle == 2'd2 && !key_sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign key_rise = armed && key_sync && !key_prev;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      mode_q <= MODE_HEX;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (key_rise) begin
      case (mode_q)
        MODE_HEX: mode_d = MODE_DEC;
        default:  mode_d = MODE_HEX;
      endcase
    end
  end

  // Double-dabble: add 3 to any BCD digit >= 5 before each shift.
  always_comb begin
    bcd = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) begin
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
      end
      bcd = {bcd[14:0], sw_q[9 - i]};
    end
  end

  always_comb begin
    LEDR = sw_q;
    HEX0 = seg_hex(sw_q[3:0]);
    HEX1 = seg_hex(sw_q[7:4]);
    HEX2 = seg_hex({2'b00, sw_q[9:8]});
    HEX3 = SEG_BLANK;
    HEX4 = SEG_BLANK;
    HEX5 = SEG_H;
    if (mode_q == MODE_DEC) begin
      HEX0 = seg_hex(bcd[3:0]);
      HEX1 = seg_hex(bcd[7:4]);
      HEX2 = seg_hex(bcd[11:8]);
      HEX3 = seg_hex(bcd[15:12]);
      HEX5 = SEG_D;
    end
  end

endmodule

// File: tb/tb_sw_hex_display.sv
// Scoreboard bench for sw_hex_display: stimulus queues expected outputs tagged
// with the cycle they must appear on; a negedge monitor pops and compares.
module tb_sw_hex_display;

  logic       CLOCK_50;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  sw_hex_display dut (
    .CLOCK_50(CLOCK_50),
    .KEY     (KEY),
    .SW      (SW),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .HEX4    (HEX4),
    .HEX5    (HEX5),
    .LEDR    (LEDR)
  );

  typedef struct {
    string       name;
    int unsigned cyc;
    logic [9:0]  led;
    logic [41:0] hex;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc;
  int unsigned compared;
  int unsigned mismatched;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic void expect_at(input string name, input int unsigned c,
                                    input logic [9:0] led,
                                    input logic [6:0] h5, input logic [6:0] h4,
                                    input logic [6:0] h3, input logic [6:0] h2,
                                    input logic [6:0] h1, input logic [6:0] h0);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.led  = led;
    e.hex  = {h5, h4, h3, h2, h1, h0};
    sb.push_back(e);
  endfunction

  always @(negedge CLOCK_50) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      compared++;
      if (mon_e.cyc != cyc || LEDR !== mon_e.led ||
          {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== mon_e.hex) begin
        mismatched++;
        $display("FAIL %s @cyc %0d (due %0d): got LEDR=%h HEX5..0=%h %h %h %h %h %h, required LEDR=%h HEX5..0=%h %h %h %h %h %h",
                 mon_e.name, cyc, mon_e.cyc, LEDR, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0,
                 mon_e.led, mon_e.hex[41:35], mon_e.hex[34:28], mon_e.hex[27:21],
                 mon_e.hex[20:14], mon_e.hex[13:7], mon_e.hex[6:0]);
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_sw_dec(input string name, input logic [9:0] v,
                            input logic [6:0] h3, input logic [6:0] h2,
                            input logic [6:0] h1, input logic [6:0] h0);
    SW = v;
    expect_at(name, cyc + 2, v, 7'h21, 7'h7F, h3, h2, h1, h0);
    step(3);
  endtask

  initial begin
    int unsigned c;
    compared   = 0;
    mismatched = 0;
    KEY = 4'b0001;
    SW  = 10'h3FF;

    // Reset with SW=3FF, held several cycles
    step(1);
    expect_at("reset", cyc, 10'h000, 7'h09, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
    expect_at("reset_hold", cyc + 2, 10'h000, 7'h09, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
    step(3);
    KEY[0] = 1'b0;
    c = cyc;
    expect_at("release_edge1", c + 1, 10'h000, 7'h09, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
    expect_at("release_edge2", c + 2, 10'h3FF, 7'h09, 7'h7F, 7'h7F, 7'h30, 7'h0E, 7'h0E);
    step(4);

    // HEX mode, SW=2A5, latency exactly 2 edges
    c = cyc;
    SW = 10'h2A5;
    expect_at("sw_lat1", c + 1, 10'h3FF, 7'h09, 7'h7F, 7'h7F, 7'h30, 7'h0E, 7'h0E);
    expect_at("hex_2a5", c + 2, 10'h2A5, 7'h09, 7'h7F, 7'h7F, 7'h24, 7'h08, 7'h12);
    step(3);

    // Press KEY[1] with SW=3FF -> DEC 1023 at the third edge
    SW = 10'h3FF;
    step(3);
    c = cyc;
    KEY[1] = 1'b1;
    expect_at("mode_pre", c + 2, 10'h3FF, 7'h09, 7'h7F, 7'h7F, 7'h30, 7'h0E, 7'h0E);
    expect_at("dec_1023", c + 3, 10'h3FF, 7'h21, 7'h7F, 7'h79, 7'h40, 7'h24, 7'h30);
    step(4);
    KEY[1] = 1'b0;
    step(3);

    // DEC sweep
    set_sw_dec("dec_0",    10'd0,    7'h40, 7'h40, 7'h40, 7'h40);
    set_sw_dec("dec_9",    10'd9,    7'h40, 7'h40, 7'h40, 7'h10);
    set_sw_dec("dec_10",   10'd10,   7'h40, 7'h40, 7'h79, 7'h40);
    set_sw_dec("dec_999",  10'd999,  7'h40, 7'h10, 7'h10, 7'h10);
    set_sw_dec("dec_1000", 10'd1000, 7'h79, 7'h40, 7'h40, 7'h40);

    // Short press back to HEX (SW=3E8)
    c = cyc;
    KEY[1] = 1'b1;
    expect_at("to_hex", c + 3, 10'h3E8, 7'h09, 7'h7F, 7'h7F, 7'h30, 7'h06, 7'h00);
    step(4);
    KEY[1] = 1'b0;
    step(3);

    // Hold KEY[1] 100 cycles: one toggle only
    c = cyc;
    KEY[1] = 1'b1;
    expect_at("hold_toggle", c + 3,   10'h3E8, 7'h21, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);
    expect_at("hold_mid",    c + 50,  10'h3E8, 7'h21, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);
    expect_at("hold_end",    c + 100, 10'h3E8, 7'h21, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);
    step(100);
    KEY[1] = 1'b0;
    step(3);
    c = cyc;
    KEY[1] = 1'b1;
    expect_at("second_press", c + 3, 10'h3E8, 7'h09, 7'h7F, 7'h7F, 7'h30, 7'h06, 7'h00);
    step(4);
    KEY[1] = 1'b0;
    step(3);

    // Back to DEC, then reset coinciding with the KEY[1] edge
    c = cyc;
    KEY[1] = 1'b1;
    expect_at("dec_again", c + 3, 10'h3E8, 7'h21, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);
    step(4);
    KEY[1] = 1'b0;
    step(3);
    c = cyc;
    KEY[1] = 1'b1;
    step(2);
    KEY[0] = 1'b1;
    expect_at("prio_pre",   c + 2, 10'h3E8, 7'h21, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);
    expect_at("prio_reset", c + 3, 10'h000, 7'h09, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
    step(1);
    KEY[0] = 1'b0;
    expect_at("prio_rel1",  c + 4, 10'h000, 7'h09, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
    expect_at("prio_rel2",  c + 5, 10'h3E8, 7'h09, 7'h7F, 7'h7F, 7'h30, 7'h06, 7'h00);
    expect_at("held_no_tg", c + 10, 10'h3E8, 7'h09, 7'h7F, 7'h7F, 7'h30, 7'h06, 7'h00);
    step(9);
    KEY[1] = 1'b0;
    step(3);
    c = cyc;
    KEY[1] = 1'b1;
    expect_at("repress", c + 3, 10'h3E8, 7'h21, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40);
    step(4);
    KEY[1] = 1'b0;
    step(3);

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got no end of stimulus by 1ms, required completion");
    $fatal(1, "timeout");
  end

endmodule
